// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy state encoding and the
// payload widths of the individual stage registers.
package pipe_pkg;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_FULL  = 2'd1;
   localparam logic [1:0] OCC_SKID  = 2'd2;

   localparam int IF_ID_W  = 64;
   localparam int ID_EX_W  = 106;
   localparam int EX_MEM_W = 72;
   // dst_reg(5) + reg_write + mem_to_reg + alu(32) + mem(32)
   localparam int MEM_WB_W = 71;

   function automatic logic [1:0] occ_state(input logic main_v, input logic skid_v);
      logic [1:0] s;
      if (!main_v)
         s = OCC_EMPTY;
      else if (skid_v)
         s = OCC_SKID;
      else
         s = OCC_FULL;
      return s;
   endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: a payload register plus its valid bit. Clearing only
// drops the valid bit; the payload keeps its last loaded value.
module pipe_entry_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = MEM_WB_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q,
   output logic              valid
);

   always_ff @(posedge clock) begin
      if (reset) begin
         q     <= '0;
         valid <= 1'b0;
      end else begin
         if (load)
            q <= d;
         if (clear)
            valid <= 1'b0;
         else if (load)
            valid <= 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, flush and an
// optional second (skid) entry that keeps in_ready off the out_ready path.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W   = MEM_WB_W,
   parameter int SKID     = 1,
   parameter int ZERO_INV = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   logic              main_valid, skid_valid;
   logic [DATA_W-1:0] main_q, skid_q, main_d;
   logic              main_load, main_clear, skid_load, skid_clear;
   logic              accept, consume;
   logic [1:0]        state;

   assign state     = occ_state(main_valid, skid_valid);
   assign occupancy = state;
   assign out_valid = main_valid;
   assign accept    = in_valid & in_ready;
   assign consume   = out_valid & out_ready;

   // With a skid entry, in_ready depends only on the skid valid flop.
   if (SKID != 0) begin : g_ready_reg
      assign in_ready = !skid_valid;
   end else begin : g_ready_comb
      assign in_ready = !main_valid | out_ready;
   end

   always_comb begin
      main_load  = 1'b0;
      main_clear = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      main_d     = in_data;
      case (state)
         OCC_EMPTY: main_load = accept;
         OCC_FULL: begin
            if (accept) begin
               if (consume)
                  main_load = 1'b1;
               else
                  skid_load = 1'b1;
            end else if (consume) begin
               main_clear = 1'b1;
            end
         end
         OCC_SKID: begin
            if (consume) begin
               main_load  = 1'b1;
               main_d     = skid_q;
               skid_clear = 1'b1;
            end
         end
         default: ;
      endcase
      // Flush drops every entry and discards a same-cycle accept.
      if (flush) begin
         main_load  = 1'b0;
         skid_load  = 1'b0;
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end
   end

   pipe_entry_reg #(.DATA_W(DATA_W)) main (
      .clock (clock),
      .reset (reset),
      .load  (main_load),
      .clear (main_clear),
      .d     (main_d),
      .q     (main_q),
      .valid (main_valid)
   );

   if (SKID != 0) begin : g_skid
      pipe_entry_reg #(.DATA_W(DATA_W)) skid (
         .clock (clock),
         .reset (reset),
         .load  (skid_load),
         .clear (skid_clear),
         .d     (in_data),
         .q     (skid_q),
         .valid (skid_valid)
      );
   end else begin : g_no_skid
      logic unused_skid_ctl;
      assign unused_skid_ctl = ^{skid_load, skid_clear};
      assign skid_q          = '0;
      assign skid_valid      = 1'b0;
   end

   // Bubbles present an all-zero payload so downstream never sees reg_write.
   if (ZERO_INV != 0) begin : g_zero_inv
      assign out_data = main_valid ? main_q : '0;
   end else begin : g_raw_out
      assign out_data = main_q;
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: one skid build (s_*) and one single-entry
// build (n_*) sharing clock and reset.
module tb_pipe_stage_skid;

   localparam int W = 71;

   logic         clock = 1'b0;
   logic         reset = 1'b1;

   logic         s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
   logic [W-1:0] s_in_data, s_out_data;
   logic [1:0]   s_occ;

   logic         n_in_valid, n_in_ready, n_flush, n_out_valid, n_out_ready;
   logic [W-1:0] n_in_data, n_out_data;
   logic [1:0]   n_occ;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   pipe_stage_skid #(.DATA_W(W), .SKID(1), .ZERO_INV(1)) dut_skid (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_data   (s_in_data),
      .flush     (s_flush),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_data  (s_out_data),
      .occupancy (s_occ)
   );

   pipe_stage_skid #(.DATA_W(W), .SKID(0), .ZERO_INV(1)) dut_single (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (n_in_valid),
      .in_ready  (n_in_ready),
      .in_data   (n_in_data),
      .flush     (n_flush),
      .out_valid (n_out_valid),
      .out_ready (n_out_ready),
      .out_data  (n_out_data),
      .occupancy (n_occ)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      s_in_valid = 1'b1; s_in_data = W'(1); s_flush = 1'b0; s_out_ready = 1'b1;
      n_in_valid = 1'b1; n_in_data = W'(1); n_flush = 1'b0; n_out_ready = 1'b1;
      step();
      step();
      checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", s_out_valid); end
      checks++; if (s_out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h want=0", s_out_data); end
      checks++; if (s_occ !== 2'd0) begin failures++; $display("FAIL reset_occupancy got=%0d want=0", s_occ); end
      checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", s_in_ready); end
      checks++; if (n_out_valid !== 1'b0) begin failures++; $display("FAIL reset_single_out_valid got=%b want=0", n_out_valid); end
      checks++; if (n_in_ready !== 1'b1) begin failures++; $display("FAIL reset_single_in_ready got=%b want=1", n_in_ready); end
      reset = 1'b0;
      s_in_valid = 1'b0;
      n_in_valid = 1'b0;
      step();
      checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%b want=0", s_out_valid); end
   endtask

   task automatic test_streaming();
      s_out_ready = 1'b1;
      s_in_valid  = 1'b1;
      s_in_data   = W'(8'h10);
      for (int i = 0; i < 8; i++) begin
         step();
         checks++; if (s_out_valid !== 1'b1 || s_out_data !== W'(8'h10 + i)) begin
            failures++; $display("FAIL stream_%0d got=%b/%h want=1/%h", i, s_out_valid, s_out_data, 8'h10 + i);
         end
         checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready_%0d got=%b want=1", i, s_in_ready); end
         if (i < 7) s_in_data = W'(8'h11 + i);
         else       s_in_valid = 1'b0;
      end
      step();
      checks++; if (s_out_valid !== 1'b0 || s_out_data !== '0 || s_occ !== 2'd0) begin
         failures++; $display("FAIL stream_drain got=%b/%h/%0d want=0/0/0", s_out_valid, s_out_data, s_occ);
      end
   endtask

   task automatic test_backpressure();
      s_out_ready = 1'b1;
      s_in_valid  = 1'b1;
      s_in_data   = W'(8'hA1);
      step();
      s_out_ready = 1'b0;
      s_in_data   = W'(8'hB2);
      step();
      checks++; if (s_occ !== 2'd2 || s_in_ready !== 1'b0) begin
         failures++; $display("FAIL bp_skid_state got=occ%0d/rdy%b want=occ2/rdy0", s_occ, s_in_ready);
      end
      checks++; if (s_out_data !== W'(8'hA1)) begin failures++; $display("FAIL bp_hold_a got=%h want=a1", s_out_data); end
      s_in_data = W'(8'hCC);
      step();
      checks++; if (s_out_data !== W'(8'hA1) || s_occ !== 2'd2) begin
         failures++; $display("FAIL bp_stable got=%h/%0d want=a1/2", s_out_data, s_occ);
      end
      s_in_valid  = 1'b0;
      s_out_ready = 1'b1;
      step();
      checks++; if (s_out_valid !== 1'b1 || s_out_data !== W'(8'hB2) || s_occ !== 2'd1) begin
         failures++; $display("FAIL bp_then_b got=%b/%h/%0d want=1/b2/1", s_out_valid, s_out_data, s_occ);
      end
      checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%b want=1", s_in_ready); end
      step();
      checks++; if (s_out_valid !== 1'b0 || s_occ !== 2'd0) begin
         failures++; $display("FAIL bp_empty got=%b/%0d want=0/0", s_out_valid, s_occ);
      end
   endtask

   task automatic test_flush();
      s_out_ready = 1'b0;
      s_in_valid  = 1'b1;
      s_in_data   = W'(8'h31);
      step();
      s_in_data = W'(8'h32);
      step();
      checks++; if (s_occ !== 2'd2) begin failures++; $display("FAIL flush_setup got=%0d want=2", s_occ); end
      s_flush   = 1'b1;
      s_in_data = W'(8'h33);
      step();
      checks++; if (s_out_valid !== 1'b0 || s_occ !== 2'd0 || s_in_ready !== 1'b1 || s_out_data !== '0) begin
         failures++; $display("FAIL flush_clear got=%b/%0d/%b/%h want=0/0/1/0", s_out_valid, s_occ, s_in_ready, s_out_data);
      end
      s_flush     = 1'b0;
      s_in_valid  = 1'b0;
      s_out_ready = 1'b1;
      step();
      checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_ghost got=%b/%h want=0", s_out_valid, s_out_data); end
   endtask

   task automatic test_reset_over_flush();
      s_out_ready = 1'b0;
      s_in_valid  = 1'b1;
      s_in_data   = W'(8'h41);
      step();
      s_in_data = W'(8'h42);
      step();
      checks++; if (s_occ !== 2'd2) begin failures++; $display("FAIL rst_flush_setup got=%0d want=2", s_occ); end
      reset   = 1'b1;
      s_flush = 1'b1;
      step();
      checks++; if (s_out_valid !== 1'b0 || s_out_data !== '0 || s_occ !== 2'd0 || s_in_ready !== 1'b1) begin
         failures++; $display("FAIL rst_over_flush got=%b/%h/%0d/%b want=0/0/0/1", s_out_valid, s_out_data, s_occ, s_in_ready);
      end
      reset      = 1'b0;
      s_flush    = 1'b0;
      s_in_valid = 1'b0;
      step();
   endtask

   task automatic test_single_ready();
      n_in_valid  = 1'b1;
      n_in_data   = W'(8'h55);
      n_out_ready = 1'b0;
      step();
      n_in_valid = 1'b0;
      #1;
      checks++; if (n_out_valid !== 1'b1 || n_in_ready !== 1'b0 || n_occ !== 2'd1) begin
         failures++; $display("FAIL single_stall got=%b/%b/%0d want=1/0/1", n_out_valid, n_in_ready, n_occ);
      end
      n_out_ready = 1'b1;
      #1;
      checks++; if (n_in_ready !== 1'b1) begin failures++; $display("FAIL single_ready_comb got=%b want=1", n_in_ready); end
      step();
      checks++; if (n_out_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b want=0", n_out_valid); end
   endtask

   task automatic test_single_random();
      logic [W-1:0] sb[$];
      logic [W-1:0] exp_d;
      int           bad = 0;
      for (int c = 0; c < 10000; c++) begin
         n_in_valid  = ($urandom_range(0, 3) != 0);
         n_out_ready = ($urandom_range(0, 2) != 0);
         n_in_data   = {7'($urandom), 32'($urandom), 32'($urandom)};
         #1;
         if (n_out_valid & n_out_ready) begin
            if (sb.size() == 0) begin
               checks++; failures++; bad++;
               if (bad < 5) $display("FAIL rand_underflow cycle=%0d got=%h want=none", c, n_out_data);
            end else begin
               exp_d = sb.pop_front();
               checks++; if (n_out_data !== exp_d) begin
                  failures++; bad++;
                  if (bad < 5) $display("FAIL rand_order cycle=%0d got=%h want=%h", c, n_out_data, exp_d);
               end
            end
         end
         if (n_in_valid & n_in_ready) sb.push_back(n_in_data);
         if (n_occ > 2'd1) begin
            checks++; failures++; bad++;
            if (bad < 5) $display("FAIL rand_occupancy cycle=%0d got=%0d want<=1", c, n_occ);
         end
         step();
      end
      n_in_valid = 1'b0;
      checks++; if (sb.size() !== (n_out_valid ? 1 : 0)) begin
         failures++; $display("FAIL rand_leftover got=%0d want=%0d", sb.size(), n_out_valid ? 1 : 0);
      end
   endtask

   initial begin
      s_in_valid = 1'b0; s_in_data = '0; s_flush = 1'b0; s_out_ready = 1'b0;
      n_in_valid = 1'b0; n_in_data = '0; n_flush = 1'b0; n_out_ready = 1'b0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_reset_over_flush();
      test_single_ready();
      test_single_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
